// File: rtl/xwalk_phase_sched.sv
// Two-road plus crosswalk phase scheduler; Moore outputs decoded from the state register, so they change one clk after a decision.
// No flow control: p and q are level-sampled each clk, and one shared down-counter times every phase.
module xwalk_phase_sched #(
  parameter int             TW        = 6,
  parameter logic [TW-1:0]  T_GREEN_A = 6'd8,
  parameter logic [TW-1:0]  T_GREEN_B = 6'd5,
  parameter logic [TW-1:0]  T_YELLOW  = 6'd2,
  parameter logic [TW-1:0]  T_ALLRED  = 6'd1,
  parameter logic [TW-1:0]  T_WALK    = 6'd6,
  parameter logic [TW-1:0]  T_CLEAR   = 6'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p,
  input  logic       q,
  output logic [1:0] ts_a,
  output logic [1:0] ts_b,
  output logic       walk,
  output logic       lid,
  output logic [2:0] phase
);

  localparam logic [2:0] S_AG  = 3'd0;
  localparam logic [2:0] S_AY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_BG  = 3'd3;
  localparam logic [2:0] S_BY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;
  localparam logic [2:0] S_PW  = 3'd6;
  localparam logic [2:0] S_PC  = 3'd7;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  // Load value for a phase of duration t; a zero duration still lasts one cycle.
  function automatic logic [TW-1:0] ld(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ped_pend_q, ped_pend_d;
  logic          ret_b_q, ret_b_d;
  logic          done;

  assign done = (timer_q == '0);

  always_comb begin
    state_d    = state_q;
    timer_d    = done ? '0 : timer_q - 1'b1;
    ped_pend_d = ped_pend_q | (p & (state_q != S_PW));
    ret_b_d    = ret_b_q;
    if (done) begin
      case (state_q)
        S_AG: begin
          // Without demand AG simply holds with the timer parked at zero.
          if (q | ped_pend_q) begin
            state_d = S_AY;
            timer_d = ld(T_YELLOW);
          end
        end
        S_AY: begin
          state_d = S_AR1;
          timer_d = ld(T_ALLRED);
        end
        S_AR1: begin
          if (ped_pend_q) begin
            state_d    = S_PW;
            timer_d    = ld(T_WALK);
            ret_b_d    = 1'b1;
            ped_pend_d = 1'b0;
          end else begin
            state_d = S_BG;
            timer_d = ld(T_GREEN_B);
          end
        end
        S_BG: begin
          state_d = S_BY;
          timer_d = ld(T_YELLOW);
        end
        S_BY: begin
          state_d = S_AR2;
          timer_d = ld(T_ALLRED);
        end
        S_AR2: begin
          if (ped_pend_q) begin
            state_d    = S_PW;
            timer_d    = ld(T_WALK);
            ret_b_d    = 1'b0;
            ped_pend_d = 1'b0;
          end else begin
            state_d = S_AG;
            timer_d = ld(T_GREEN_A);
          end
        end
        S_PW: begin
          state_d = S_PC;
          timer_d = ld(T_CLEAR);
        end
        default: begin
          if (ret_b_q & q) begin
            state_d = S_BG;
            timer_d = ld(T_GREEN_B);
          end else begin
            state_d = S_AG;
            timer_d = ld(T_GREEN_A);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_AG;
      timer_q    <= ld(T_GREEN_A);
      ped_pend_q <= 1'b0;
      ret_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      ret_b_q    <= ret_b_d;
    end
  end

  always_comb begin
    ts_a = L_RED;
    ts_b = L_RED;
    case (state_q)
      S_AG:    ts_a = L_GREEN;
      S_AY:    ts_a = L_YELLOW;
      S_BG:    ts_b = L_GREEN;
      S_BY:    ts_b = L_YELLOW;
      default: begin
        ts_a = L_RED;
        ts_b = L_RED;
      end
    endcase
  end

  assign walk  = (state_q == S_PW);
  assign lid   = ped_pend_q;
  assign phase = state_q;

endmodule

// File: tb/tb_xwalk_phase_sched.sv
// Random and directed traffic against a phase/elapsed-time reference model.
// Expected outputs are queued per cycle; a separate monitor pops and compares.
module tb_xwalk_phase_sched;

  logic       clk;
  logic       reset;
  logic       p;
  logic       q;
  logic [1:0] ts_a;
  logic [1:0] ts_b;
  logic       walk;
  logic       lid;
  logic [2:0] phase;

  xwalk_phase_sched dut (
    .clk   (clk),
    .reset (reset),
    .p     (p),
    .q     (q),
    .ts_a  (ts_a),
    .ts_b  (ts_b),
    .walk  (walk),
    .lid   (lid),
    .phase (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] ph;
    logic [1:0] a;
    logic [1:0] b;
    logic       w;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   drv_done = 1'b0;

  // Reference model: phase number, cycles already spent in it, pending request, return-to-B flag.
  int m_ph;
  int m_el;
  bit m_pend;
  bit m_retb;

  function automatic int dur(input int ph);
    int t;
    case (ph)
      0: t = 8;
      1: t = 2;
      2: t = 1;
      3: t = 5;
      4: t = 2;
      5: t = 1;
      6: t = 6;
      default: t = 3;
    endcase
    return (t < 1) ? 1 : t;
  endfunction

  task automatic model_reset();
    m_ph = 0;
    m_el = 0;
    m_pend = 1'b0;
    m_retb = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.ph = m_ph[2:0];
    e.a  = (m_ph == 0) ? 2'b00 : (m_ph == 1) ? 2'b01 : 2'b10;
    e.b  = (m_ph == 3) ? 2'b00 : (m_ph == 4) ? 2'b01 : 2'b10;
    e.w  = (m_ph == 6);
    e.l  = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic model_adv(input bit pp, input bit qq);
    bit last;
    bit np;
    int nx;
    last = (m_el + 1 >= dur(m_ph));
    np = m_pend | (pp && m_ph != 6);
    if (!last) begin
      m_el++;
    end else begin
      case (m_ph)
        0: nx = (qq || m_pend) ? 1 : 0;
        1: nx = 2;
        2: nx = m_pend ? 6 : 3;
        3: nx = 4;
        4: nx = 5;
        5: nx = m_pend ? 6 : 0;
        6: nx = 7;
        default: nx = (m_retb && qq) ? 3 : 0;
      endcase
      if (nx == 6) begin
        np = 1'b0;
        m_retb = (m_ph == 2);
      end
      if (nx == m_ph) m_el++;
      else m_el = 0;
      m_ph = nx;
    end
    m_pend = np;
  endtask

  task automatic step(input bit pp, input bit qq);
    @(negedge clk);
    reset = 1'b1;
    p = pp;
    q = qq;
    push_exp();
    model_adv(pp, qq);
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    reset = 1'b0;
    p = 1'b0;
    q = 1'b0;
    model_reset();
    push_exp();
  endtask

  task automatic run_until(input int ph, input bit pp, input bit qq);
    int n;
    n = 0;
    while (m_ph != ph && n < 100) begin
      step(pp, qq);
      n++;
    end
    checks++;
    if (m_ph != ph) begin
      errors++;
      $display("FAIL reach_phase: model phase %0d, wanted %0d within 100 cycles", m_ph, ph);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (phase !== e.ph || ts_a !== e.a || ts_b !== e.b || walk !== e.w || lid !== e.l) begin
          errors++;
          $display("FAIL outputs t=%0t: got ph=%0d a=%b b=%b w=%b l=%b, want ph=%0d a=%b b=%b w=%b l=%b",
                   $time, phase, ts_a, ts_b, walk, lid, e.ph, e.a, e.b, e.w, e.l);
        end
        checks++;
        if ((ts_a !== 2'b10 && ts_b !== 2'b10) || (walk === 1'b1 && (ts_a !== 2'b10 || ts_b !== 2'b10))) begin
          errors++;
          $display("FAIL safety t=%0t: got a=%b b=%b w=%b, want at least one red and all red while walking",
                   $time, ts_a, ts_b, walk);
        end
      end else if (!drv_done && checks > 0) begin
        checks++;
        errors++;
        $display("FAIL queue_underrun t=%0t: got empty expectation queue, want one entry per cycle", $time);
      end
    end
  end

  initial begin
    reset = 1'b1;
    p = 1'b0;
    q = 1'b0;
    model_reset();

    rst_cyc();
    rst_cyc();

    // Idle: AG held forever.
    repeat (50) step(1'b0, 1'b0);

    // Road B demand only: full vehicle cycle, twice.
    repeat (40) step(1'b0, 1'b1);

    // Fresh start, single pedestrian pulse at cycle 3.
    rst_cyc();
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);

    // Pedestrian and road B together in AG.
    rst_cyc();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1);

    // p held through PW, then pulsed in PC.
    rst_cyc();
    step(1'b1, 1'b0);
    run_until(6, 1'b0, 1'b0);
    while (m_ph == 6) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0);

    // Reset mid-BG.
    rst_cyc();
    run_until(3, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst_cyc();
    repeat (25) step(1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) rst_cyc();
      else step($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
    end

    drv_done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
